// File: rtl/riscv_bru.sv
// riscv_bru: EX-stage branch-resolution unit.
//   Resolves conditional branches, JAL, JALR and FENCE.I and checks them
//   against the fetch predictor. It also keeps a circular return-stack buffer
//   to verify JALR returns, a global branch-history register, and a FENCE.I
//   handshake that holds EX until the cache subsystem acknowledges.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   id_*                     instruction presented by ID (op, pc, imm, rvc, rd, rs1)
//   opA_i, opB_i             operands (compare inputs, JALR base + offset)
//   id_bp_predict_i          predictor state, bit 1 = predicted taken
//   ex_stall_i, st_flush_i   EX hold and pipeline flush
//   cm_ack_i                 cache maintenance complete pulse
//   bu_*                     registered resolution results toward IF/BP
//   cm_ic_invalidate_o,
//   cm_dc_clean_o            single-cycle cache maintenance commands
module riscv_bru #(
   parameter int              XLEN           = 32,
   parameter logic [XLEN-1:0] PC_INIT        = 'h200,
   parameter int              BP_GLOBAL_BITS = 2,
   parameter int              RSB_DEPTH      = 4,
   parameter int              HAS_RVC        = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      id_valid_i,
   input  logic [3:0]                id_op_i,
   input  logic [XLEN-1:0]           id_pc_i,
   input  logic [XLEN-1:0]           id_imm_i,
   input  logic                      id_rvc_i,
   input  logic [4:0]                id_rd_i,
   input  logic [4:0]                id_rs1_i,
   input  logic [XLEN-1:0]           opA_i,
   input  logic [XLEN-1:0]           opB_i,
   input  logic [1:0]                id_bp_predict_i,
   input  logic                      ex_stall_i,
   input  logic                      st_flush_i,
   input  logic                      cm_ack_i,
   output logic                      bu_valid_o,
   output logic                      bu_flush_o,
   output logic [XLEN-1:0]           bu_nxt_pc_o,
   output logic                      bu_btaken_o,
   output logic                      bu_bp_update_o,
   output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
   output logic                      bu_misaligned_o,
   output logic                      bu_stall_o,
   output logic                      cm_ic_invalidate_o,
   output logic                      cm_dc_clean_o
);

   localparam logic [3:0] OP_JAL   = 4'd1, OP_JALR = 4'd2, OP_BEQ  = 4'd3,
                          OP_BNE   = 4'd4, OP_BLT  = 4'd5, OP_BGE  = 4'd6,
                          OP_BLTU  = 4'd7, OP_BGEU = 4'd8, OP_FENCEI = 4'd9;

   // Depth 0 keeps a two-entry dummy array so all widths stay legal; it is
   // never written because every RSB action is gated by HAS_RSB.
   localparam bit HAS_RSB = (RSB_DEPTH != 0);
   localparam int RSB_ENT = (RSB_DEPTH < 2) ? 2 : RSB_DEPTH;
   localparam int PTR_W   = $clog2(RSB_ENT);
   localparam int CNT_W   = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e                  state_q;
   logic [BP_GLOBAL_BITS:0] hist_q;
   logic [XLEN-1:0]         fence_pc_q;
   logic [XLEN-1:0]         rsb_mem [RSB_ENT];
   logic [PTR_W-1:0]        rsb_ptr_q;
   logic [CNT_W-1:0]        rsb_cnt_q;

   logic is_br, is_jal, is_jalr, is_fencei, taken;
   logic [XLEN-1:0] pc_len, pc_imm, jalr_tgt, target, pop_val;
   logic redirect, misal, rd_link, rs1_link;
   logic rsb_push, pop_req, pop_ok, pop_do, jalr_hit, flush_nxt, accept;
   logic [PTR_W-1:0] ptr_dec, ptr_pop;
   logic [CNT_W-1:0] cnt_pop;
   logic unused_bits;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      is_br     = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_fencei = 1'b0;
      taken     = 1'b0;
      case (id_op_i)
         OP_JAL:    is_jal    = 1'b1;
         OP_JALR:   is_jalr   = 1'b1;
         OP_BEQ:    begin is_br = 1'b1; taken = (opA_i == opB_i); end
         OP_BNE:    begin is_br = 1'b1; taken = (opA_i != opB_i); end
         OP_BLT:    begin is_br = 1'b1; taken = ($signed(opA_i) <  $signed(opB_i)); end
         OP_BGE:    begin is_br = 1'b1; taken = ($signed(opA_i) >= $signed(opB_i)); end
         OP_BLTU:   begin is_br = 1'b1; taken = (opA_i <  opB_i); end
         OP_BGEU:   begin is_br = 1'b1; taken = (opA_i >= opB_i); end
         OP_FENCEI: is_fencei = 1'b1;
         default:   ;
      endcase
   end

   assign pc_len   = id_pc_i + (id_rvc_i ? XLEN'(2) : XLEN'(4));
   assign pc_imm   = id_pc_i + id_imm_i;
   assign jalr_tgt = (opA_i + opB_i) & ~XLEN'(1);

   always_comb begin
      target = pc_len;
      if (is_jalr)                     target = jalr_tgt;
      else if (is_jal || (is_br && taken)) target = pc_imm;
   end

   // Only redirecting targets can fault; the fall-through PC is always aligned.
   assign redirect = is_jal | is_jalr | (is_br & taken);
   assign misal    = redirect & ((HAS_RVC != 0) ? target[0] : (target[1:0] != 2'b00));

   assign rd_link  = (id_rd_i  == 5'd1) || (id_rd_i  == 5'd5);
   assign rs1_link = (id_rs1_i == 5'd1) || (id_rs1_i == 5'd5);

   // rd==rs1 with both link registers is a coroutine-style push, not a return.
   assign rsb_push = HAS_RSB & ~misal & (is_jal | is_jalr) & rd_link;
   assign pop_req  = HAS_RSB & is_jalr & rs1_link & ~(rd_link & (id_rs1_i == id_rd_i));
   assign pop_ok   = pop_req & (rsb_cnt_q != '0);
   assign pop_do   = pop_ok & ~misal;
   assign ptr_dec  = rsb_ptr_q - PTR_W'(1);
   assign pop_val  = rsb_mem[ptr_dec];
   assign jalr_hit = pop_ok & (pop_val[XLEN-1:1] == jalr_tgt[XLEN-1:1]);

   // Pop happens before push, so a pop+push rewrites the slot just vacated.
   assign ptr_pop = pop_do ? ptr_dec : rsb_ptr_q;
   assign cnt_pop = pop_do ? rsb_cnt_q - CNT_W'(1) : rsb_cnt_q;

   always_comb begin
      flush_nxt = 1'b0;
      if (misal)        flush_nxt = 1'b0;
      else if (is_br)   flush_nxt = taken ^ id_bp_predict_i[1];
      else if (is_jal)  flush_nxt = ~id_bp_predict_i[1];
      else if (is_jalr) flush_nxt = ~jalr_hit;
   end

   assign accept = id_valid_i & ~ex_stall_i & ~st_flush_i & ~bu_flush_o & (state_q == S_IDLE);

   assign bu_bp_history_o = hist_q[BP_GLOBAL_BITS:1];
   assign unused_bits     = ^{id_bp_predict_i[0], pop_val[0]};

   // NOTE: the RSB storage has no reset; the count gates every read, so stale
   // contents are never observed and the array can map onto plain registers/RAM.
   always_ff @(posedge clk_i) begin
      if (accept && rsb_push) rsb_mem[ptr_pop] <= pc_len;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q            <= S_IDLE;
         hist_q             <= '0;
         fence_pc_q         <= '0;
         rsb_ptr_q          <= '0;
         rsb_cnt_q          <= '0;
         bu_valid_o         <= 1'b0;
         bu_flush_o         <= 1'b1;
         bu_nxt_pc_o        <= PC_INIT;
         bu_btaken_o        <= 1'b0;
         bu_bp_update_o     <= 1'b0;
         bu_misaligned_o    <= 1'b0;
         bu_stall_o         <= 1'b0;
         cm_ic_invalidate_o <= 1'b0;
         cm_dc_clean_o      <= 1'b0;
      end else begin
         // Cache commands are strictly one-cycle pulses, even under a stall.
         cm_ic_invalidate_o <= 1'b0;
         cm_dc_clean_o      <= 1'b0;
         if (!ex_stall_i) begin
            bu_valid_o     <= 1'b0;
            bu_flush_o     <= 1'b0;
            bu_bp_update_o <= 1'b0;
            case (state_q)
               S_IDLE: begin
                  if (accept) begin
                     bu_valid_o      <= is_br | is_jal | is_jalr;
                     bu_flush_o      <= flush_nxt;
                     bu_btaken_o     <= redirect;
                     bu_bp_update_o  <= is_br & ~misal;
                     bu_misaligned_o <= misal;
                     if (is_br || is_jal || is_jalr) bu_nxt_pc_o <= target;
                     if (is_br && !misal) hist_q <= {hist_q[BP_GLOBAL_BITS-1:0], taken};
                     if (rsb_push) begin
                        rsb_ptr_q <= ptr_pop + PTR_W'(1);
                        rsb_cnt_q <= (cnt_pop == CNT_W'(RSB_DEPTH)) ? cnt_pop : cnt_pop + CNT_W'(1);
                     end else begin
                        rsb_ptr_q <= ptr_pop;
                        rsb_cnt_q <= cnt_pop;
                     end
                     if (is_fencei) begin
                        cm_ic_invalidate_o <= 1'b1;
                        cm_dc_clean_o      <= 1'b1;
                        fence_pc_q         <= pc_len;
                        bu_stall_o         <= 1'b1;
                        state_q            <= S_WAIT;
                     end
                  end
               end
               // st_flush_i deliberately has no effect here: the cache
               // operation is already under way and must be seen through.
               S_WAIT: begin
                  if (cm_ack_i) begin
                     bu_valid_o      <= 1'b1;
                     bu_flush_o      <= 1'b1;
                     bu_nxt_pc_o     <= fence_pc_q;
                     bu_btaken_o     <= 1'b0;
                     bu_misaligned_o <= 1'b0;
                     state_q         <= S_DONE;
                  end
               end
               S_DONE: begin
                  bu_stall_o <= 1'b0;
                  state_q    <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_riscv_bru.sv
// tb_riscv_bru: self-checking bench for riscv_bru (XLEN 32, RSB_DEPTH 4,
// BP_GLOBAL_BITS 2, HAS_RVC 0). Expected results are queued when stimulus is
// driven and popped when the unit presents its registered result.
module tb_riscv_bru;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        id_valid_i;
   logic [3:0]  id_op_i;
   logic [31:0] id_pc_i, id_imm_i, opA_i, opB_i;
   logic        id_rvc_i;
   logic [4:0]  id_rd_i, id_rs1_i;
   logic [1:0]  id_bp_predict_i;
   logic        ex_stall_i, st_flush_i, cm_ack_i;
   logic        bu_valid_o, bu_flush_o, bu_btaken_o, bu_bp_update_o;
   logic [31:0] bu_nxt_pc_o;
   logic [1:0]  bu_bp_history_o;
   logic        bu_misaligned_o, bu_stall_o, cm_ic_invalidate_o, cm_dc_clean_o;

   always #5 clk_i = ~clk_i;

   riscv_bru #(.XLEN(32), .PC_INIT(32'h200), .BP_GLOBAL_BITS(2), .RSB_DEPTH(4), .HAS_RVC(0)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_op_i(id_op_i),
      .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_rvc_i(id_rvc_i), .id_rd_i(id_rd_i),
      .id_rs1_i(id_rs1_i), .opA_i(opA_i), .opB_i(opB_i), .id_bp_predict_i(id_bp_predict_i),
      .ex_stall_i(ex_stall_i), .st_flush_i(st_flush_i), .cm_ack_i(cm_ack_i),
      .bu_valid_o(bu_valid_o), .bu_flush_o(bu_flush_o), .bu_nxt_pc_o(bu_nxt_pc_o),
      .bu_btaken_o(bu_btaken_o), .bu_bp_update_o(bu_bp_update_o),
      .bu_bp_history_o(bu_bp_history_o), .bu_misaligned_o(bu_misaligned_o),
      .bu_stall_o(bu_stall_o), .cm_ic_invalidate_o(cm_ic_invalidate_o),
      .cm_dc_clean_o(cm_dc_clean_o)
   );

   localparam logic [3:0] JAL = 4'd1, JALR = 4'd2, BEQ = 4'd3, BNE = 4'd4, BLT = 4'd5,
                          BGE = 4'd6, BLTU = 4'd7, BGEU = 4'd8, FENCEI = 4'd9;

   typedef struct packed {
      logic        flush;
      logic        btaken;
      logic        bp_upd;
      logic        mis;
      logic [1:0]  hist;
      logic [31:0] pc;
   } res_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [1:0]  pred;
      logic        rvc;
      logic        tk;
   } bcase_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] pc, imm, a, b;
      logic [4:0]  rd, rs1;
      logic [1:0]  pred;
      logic        flush;
      logic [31:0] nxt;
   } jcase_t;

   res_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic [2:0] h_model = '0;

   bcase_t bcases [8] = '{
      '{BEQ,  32'd5,        32'd5,        2'b00, 1'b0, 1'b1},
      '{BLT,  32'hFFFFFFFF, 32'd1,        2'b10, 1'b0, 1'b1},
      '{BLTU, 32'hFFFFFFFF, 32'd1,        2'b10, 1'b0, 1'b0},
      '{BNE,  32'd3,        32'd3,        2'b00, 1'b0, 1'b0},
      '{BGE,  32'd1,        32'hFFFFFFFF, 2'b00, 1'b0, 1'b1},
      '{BGEU, 32'd1,        32'hFFFFFFFF, 2'b10, 1'b0, 1'b0},
      '{BEQ,  32'd1,        32'd2,        2'b10, 1'b1, 1'b0},
      '{BGE,  32'd7,        32'd7,        2'b10, 1'b0, 1'b1}
   };

   jcase_t jcases [9] = '{
      '{JAL,  32'h200, 32'h40,  32'h0,   32'h0, 5'd1, 5'd0, 2'b10, 1'b0, 32'h240},
      '{JALR, 32'h240, 32'h0,   32'h204, 32'h0, 5'd0, 5'd1, 2'b00, 1'b0, 32'h204},
      '{JAL,  32'h200, 32'h40,  32'h0,   32'h0, 5'd1, 5'd0, 2'b10, 1'b0, 32'h240},
      '{JALR, 32'h240, 32'h0,   32'h200, 32'h8, 5'd0, 5'd1, 2'b00, 1'b1, 32'h208},
      '{JAL,  32'h600, 32'h100, 32'h0,   32'h0, 5'd1, 5'd0, 2'b00, 1'b1, 32'h700},
      '{JALR, 32'h700, 32'h0,   32'h600, 32'h4, 5'd5, 5'd1, 2'b00, 1'b0, 32'h604},
      '{JALR, 32'h604, 32'h0,   32'h704, 32'h0, 5'd0, 5'd5, 2'b00, 1'b0, 32'h704},
      '{JALR, 32'h704, 32'h0,   32'h10,  32'h0, 5'd1, 5'd1, 2'b00, 1'b1, 32'h10},
      '{JALR, 32'h10,  32'h0,   32'h708, 32'h1, 5'd0, 5'd1, 2'b00, 1'b0, 32'h708}
   };

   function automatic res_t observed();
      res_t r;
      r.flush = bu_flush_o;  r.btaken = bu_btaken_o; r.bp_upd = bu_bp_update_o;
      r.mis   = bu_misaligned_o; r.hist = bu_bp_history_o; r.pc = bu_nxt_pc_o;
      return r;
   endfunction

   function automatic res_t mk(input logic flush, btaken, bp, mis, input logic [31:0] pc);
      res_t r;
      r.flush = flush; r.btaken = btaken; r.bp_upd = bp; r.mis = mis;
      r.hist = h_model[2:1]; r.pc = pc;
      return r;
   endfunction

   task automatic set_inputs(input logic [3:0] op, input logic [31:0] pc, imm, a, b,
                             input logic [4:0] rd, rs1, input logic rvc, input logic [1:0] pred);
      id_op_i = op; id_pc_i = pc; id_imm_i = imm; opA_i = a; opB_i = b;
      id_rd_i = rd; id_rs1_i = rs1; id_rvc_i = rvc; id_bp_predict_i = pred;
      id_valid_i = 1'b1;
   endtask

   // Presents one instruction for one cycle; returns at the negedge after the
   // accepting edge, where its registered result is visible.
   task automatic drive(input logic [3:0] op, input logic [31:0] pc, imm, a, b,
                        input logic [4:0] rd, rs1, input logic rvc, input logic [1:0] pred);
      @(negedge clk_i);
      set_inputs(op, pc, imm, a, b, rd, rs1, rvc, pred);
      @(negedge clk_i);
      id_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [38:0] got;
      repeat (2) @(negedge clk_i);
      got = {bu_valid_o, bu_flush_o, bu_btaken_o, bu_bp_update_o, bu_misaligned_o, bu_stall_o,
             cm_ic_invalidate_o, cm_dc_clean_o, bu_bp_history_o, bu_nxt_pc_o[28:0]};
      total++;
      if (got !== {8'b01000000, 2'b00, 29'h200} || bu_nxt_pc_o !== 32'h200) begin
         bad++;
         $display("FAIL reset: got outputs=%h pc=%h, expected flush only and pc=00000200", got, bu_nxt_pc_o);
      end
      rst_ni = 1'b1;
   endtask

   task automatic test_branches();
      res_t e;
      logic [31:0] tgt;
      for (int i = 0; i < 8; i++) begin
         tgt = bcases[i].tk ? 32'h120 : (bcases[i].rvc ? 32'h102 : 32'h104);
         h_model = {h_model[1:0], bcases[i].tk};
         sb.push_back(mk(bcases[i].tk ^ bcases[i].pred[1], bcases[i].tk, 1'b1, 1'b0, tgt));
         drive(bcases[i].op, 32'h100, 32'h20, bcases[i].a, bcases[i].b, 5'd0, 5'd0,
               bcases[i].rvc, bcases[i].pred);
         e = sb.pop_front();
         total++;
         if (bu_valid_o !== 1'b1 || observed() !== e) begin
            bad++;
            $display("FAIL branch[%0d]: got valid=%b res=%h, expected valid=1 res=%h", i, bu_valid_o, observed(), e);
         end
      end
   endtask

   task automatic test_jal_jalr();
      res_t e;
      for (int i = 0; i < 9; i++) begin
         sb.push_back(mk(jcases[i].flush, 1'b1, 1'b0, 1'b0, jcases[i].nxt));
         drive(jcases[i].op, jcases[i].pc, jcases[i].imm, jcases[i].a, jcases[i].b,
               jcases[i].rd, jcases[i].rs1, 1'b0, jcases[i].pred);
         e = sb.pop_front();
         total++;
         if (bu_valid_o !== 1'b1 || observed() !== e) begin
            bad++;
            $display("FAIL jump[%0d]: got valid=%b res=%h, expected valid=1 res=%h", i, bu_valid_o, observed(), e);
         end
      end
   endtask

   task automatic test_rsb_overflow();
      res_t e;
      logic [31:0] pc;
      for (int i = 0; i < 5; i++) begin
         pc = (i + 1) << 12;
         sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, pc + 32'h10));
         drive(JAL, pc, 32'h10, 32'h0, 32'h0, 5'd5, 5'd0, 1'b0, 2'b10);
         e = sb.pop_front();
         total++;
         if (bu_valid_o !== 1'b1 || observed() !== e) begin
            bad++;
            $display("FAIL call[%0d]: got valid=%b res=%h, expected valid=1 res=%h", i, bu_valid_o, observed(), e);
         end
      end
      for (int i = 0; i < 5; i++) begin
         pc = ((5 - i) << 12) + 4;
         sb.push_back(mk(i == 4, 1'b1, 1'b0, 1'b0, pc));
         drive(JALR, 32'h8000, 32'h0, pc, 32'h0, 5'd0, 5'd5, 1'b0, 2'b00);
         e = sb.pop_front();
         total++;
         if (bu_valid_o !== 1'b1 || observed() !== e) begin
            bad++;
            $display("FAIL return[%0d]: got valid=%b res=%h, expected valid=1 res=%h", i, bu_valid_o, observed(), e);
         end
      end
   endtask

   task automatic test_misaligned();
      res_t e;
      // JALR target 0x102 with a link rd: faults, no flush, nothing pushed.
      drive(JALR, 32'h400, 32'h0, 32'h100, 32'h2, 5'd1, 5'd0, 1'b0, 2'b00);
      total++;
      if ({bu_valid_o, bu_misaligned_o, bu_flush_o} !== 3'b110) begin
         bad++;
         $display("FAIL mis_jalr: got valid/mis/flush=%b, expected 110", {bu_valid_o, bu_misaligned_o, bu_flush_o});
      end
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h404));
      drive(JALR, 32'h404, 32'h0, 32'h404, 32'h0, 5'd0, 5'd1, 1'b0, 2'b00);
      e = sb.pop_front();
      total++;
      if (bu_valid_o !== 1'b1 || observed() !== e) begin
         bad++;
         $display("FAIL mis_rsb_kept: got valid=%b res=%h, expected valid=1 res=%h", bu_valid_o, observed(), e);
      end
      // Taken BNE to 0x122: faults, and its outcome stays out of the history.
      drive(BNE, 32'h100, 32'h22, 32'h1, 32'h2, 5'd0, 5'd0, 1'b0, 2'b00);
      total++;
      if ({bu_misaligned_o, bu_flush_o, bu_bp_history_o} !== {2'b10, h_model[2:1]}) begin
         bad++;
         $display("FAIL mis_branch: got mis/flush/hist=%b, expected %b", {bu_misaligned_o, bu_flush_o, bu_bp_history_o}, {2'b10, h_model[2:1]});
      end
      h_model = {h_model[1:0], 1'b1};
      sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h120));
      drive(BEQ, 32'h100, 32'h20, 32'h4, 32'h4, 5'd0, 5'd0, 1'b0, 2'b10);
      e = sb.pop_front();
      total++;
      if (bu_valid_o !== 1'b1 || observed() !== e) begin
         bad++;
         $display("FAIL mis_hist_kept: got valid=%b res=%h, expected valid=1 res=%h", bu_valid_o, observed(), e);
      end
   endtask

   task automatic test_drop();
      res_t e;
      // Mispredicted BEQ, then a JAL x1 in ID during the flush cycle.
      @(negedge clk_i);
      set_inputs(BEQ, 32'h100, 32'h20, 32'h5, 32'h5, 5'd0, 5'd0, 1'b0, 2'b00);
      h_model = {h_model[1:0], 1'b1};
      sb.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h120));
      @(negedge clk_i);
      e = sb.pop_front();
      total++;
      if (bu_valid_o !== 1'b1 || observed() !== e) begin
         bad++;
         $display("FAIL drop_branch: got valid=%b res=%h, expected valid=1 res=%h", bu_valid_o, observed(), e);
      end
      set_inputs(JAL, 32'h900, 32'h10, 32'h0, 32'h0, 5'd1, 5'd0, 1'b0, 2'b10);
      @(negedge clk_i);
      id_valid_i = 1'b0;
      total++;
      if (bu_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL drop_wrong_path: got valid=%b, expected 0", bu_valid_o);
      end
      // A call killed by st_flush_i in its accept cycle.
      @(negedge clk_i);
      set_inputs(JAL, 32'hA00, 32'h10, 32'h0, 32'h0, 5'd1, 5'd0, 1'b0, 2'b10);
      st_flush_i = 1'b1;
      @(negedge clk_i);
      id_valid_i = 1'b0;
      st_flush_i = 1'b0;
      total++;
      if (bu_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL drop_st_flush: got valid=%b, expected 0", bu_valid_o);
      end
      // Neither dropped call may have pushed: both returns miss.
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, i == 0 ? 32'h904 : 32'hA04));
         drive(JALR, 32'hC00, 32'h0, i == 0 ? 32'h904 : 32'hA04, 32'h0, 5'd0, 5'd1, 1'b0, 2'b00);
         e = sb.pop_front();
         total++;
         if (bu_valid_o !== 1'b1 || observed() !== e) begin
            bad++;
            $display("FAIL drop_rsb[%0d]: got valid=%b res=%h, expected valid=1 res=%h", i, bu_valid_o, observed(), e);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t e;
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk_i);
         if (i > 0) begin
            e = sb.pop_front();
            total++;
            if (bu_valid_o !== 1'b1 || observed() !== e) begin
               bad++;
               $display("FAIL b2b[%0d]: got valid=%b res=%h, expected valid=1 res=%h", i - 1, bu_valid_o, observed(), e);
            end
         end
         case (i)
            0: begin
               set_inputs(BNE, 32'h100, 32'h20, 32'h1, 32'h1, 5'd0, 5'd0, 1'b0, 2'b00);
               h_model = {h_model[1:0], 1'b0};
               sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h104));
            end
            1: begin
               set_inputs(BEQ, 32'h200, 32'h40, 32'h2, 32'h2, 5'd0, 5'd0, 1'b0, 2'b10);
               h_model = {h_model[1:0], 1'b1};
               sb.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h240));
            end
            2: begin
               set_inputs(JAL, 32'h300, 32'h8, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 2'b10);
               sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h308));
            end
            default: id_valid_i = 1'b0;
         endcase
      end
   endtask

   task automatic test_fencei();
      res_t e;
      logic quiet;
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h304));
      drive(FENCEI, 32'h300, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 2'b00);
      total++;
      if ({cm_ic_invalidate_o, cm_dc_clean_o, bu_stall_o} !== 3'b111) begin
         bad++;
         $display("FAIL fence_cmd: got ic/dc/stall=%b, expected 111", {cm_ic_invalidate_o, cm_dc_clean_o, bu_stall_o});
      end
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         st_flush_i = (i == 1);
         if (cm_ic_invalidate_o || cm_dc_clean_o || !bu_stall_o || bu_valid_o) quiet = 1'b0;
      end
      st_flush_i = 1'b0;
      total++;
      if (quiet !== 1'b1) begin
         bad++;
         $display("FAIL fence_wait: got pulse/valid during wait or stall dropped, expected stall only");
      end
      cm_ack_i = 1'b1;
      @(negedge clk_i);
      cm_ack_i = 1'b0;
      e = sb.pop_front();
      total++;
      if ({bu_valid_o, bu_flush_o, bu_stall_o} !== 3'b111 || bu_nxt_pc_o !== e.pc) begin
         bad++;
         $display("FAIL fence_done: got valid/flush/stall=%b pc=%h, expected 111 pc=%h", {bu_valid_o, bu_flush_o, bu_stall_o}, bu_nxt_pc_o, e.pc);
      end
      @(negedge clk_i);
      total++;
      if ({bu_valid_o, bu_stall_o} !== 2'b00) begin
         bad++;
         $display("FAIL fence_idle: got valid/stall=%b, expected 00", {bu_valid_o, bu_stall_o});
      end
   endtask

   task automatic test_reset_mid_fence();
      logic quiet;
      drive(FENCEI, 32'h500, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 2'b00);
      repeat (2) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      total++;
      if ({bu_stall_o, bu_flush_o, cm_ic_invalidate_o, cm_dc_clean_o} !== 4'b0100 || bu_nxt_pc_o !== 32'h200) begin
         bad++;
         $display("FAIL reset_mid_fence: got stall/flush/ic/dc=%b pc=%h, expected 0100 pc=00000200",
                  {bu_stall_o, bu_flush_o, cm_ic_invalidate_o, cm_dc_clean_o}, bu_nxt_pc_o);
      end
      @(negedge clk_i);
      rst_ni  = 1'b1;
      h_model = '0;
      cm_ack_i = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         cm_ack_i = 1'b0;
         if (bu_valid_o || bu_stall_o || cm_ic_invalidate_o || cm_dc_clean_o) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin
         bad++;
         $display("FAIL reset_no_reissue: got activity after reset, expected idle unit");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni = 1'b0; id_valid_i = 1'b0; id_op_i = '0; id_pc_i = '0; id_imm_i = '0;
      opA_i = '0; opB_i = '0; id_rvc_i = 1'b0; id_rd_i = '0; id_rs1_i = '0;
      id_bp_predict_i = '0; ex_stall_i = 1'b0; st_flush_i = 1'b0; cm_ack_i = 1'b0;
      test_reset();
      test_branches();
      test_jal_jalr();
      test_rsb_overflow();
      test_misaligned();
      test_drop();
      test_back_to_back();
      test_fencei();
      test_reset_mid_fence();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_bru.md
# riscv_bru

Parametrised branch-resolution unit for the EX stage. It resolves conditional branches, JAL, JALR and FENCE.I, and checks them against the fetch predictor. It adds three things over the previous generation:
- an internal circular return-stack buffer (RSB) of configurable depth, which verifies JALR returns;
- a configurable global-history shift register;
- a FENCE.I handshake state machine that holds EX until the cache subsystem acknowledges.

All outputs are registered and feed the IF/BP stages and the cache controllers.

## Interface
- XLEN, 32, datapath and PC width.
- PC_INIT, 'h200, PC driven on bu_nxt_pc_o after reset.
- BP_GLOBAL_BITS, 2, global history length (1–16).
- RSB_DEPTH, 4, RSB entries. 0 removes the RSB; otherwise a power of 2 from 2 to 32.
- HAS_RVC, 0, non-zero enables 16-bit instruction alignment rules.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  ID presents an instruction.
- id_op_i  in  4  0 NONE, 1 JAL, 2 JALR, 3 BEQ, 4 BNE, 5 BLT, 6 BGE, 7 BLTU, 8 BGEU, 9 FENCEI; others are treated as NONE.
- id_pc_i  in  XLEN  instruction PC.
- id_imm_i  in  XLEN  sign-extended immediate.
- id_rvc_i  in  1  instruction is 16-bit.
- id_rd_i, id_rs1_i  in  5 each  register indices.
- opA_i, opB_i  in  XLEN  operands. For JALR, target = (opA_i+opB_i) & ~1.
- id_bp_predict_i  in  2  bit 1 = predicted taken.
- ex_stall_i  in  1  hold EX.
- st_flush_i  in  1  pipeline flush from state unit.
- cm_ack_i  in  1  cache maintenance complete (single-cycle pulse).
- bu_valid_o  out  1  a resolved instruction is presented.
- bu_flush_o  out  1  redirect fetch to bu_nxt_pc_o.
- bu_nxt_pc_o  out  XLEN  resolved next PC.
- bu_btaken_o  out  1  branch/jump taken.
- bu_bp_update_o  out  1  conditional branch resolved; the predictor must update.
- bu_bp_history_o  out  BP_GLOBAL_BITS  history excluding the current branch.
- bu_misaligned_o  out  1  misaligned-target exception.
- bu_stall_o  out  1  FENCE.I in progress.
- cm_ic_invalidate_o, cm_dc_clean_o  out  1  single-cycle cache commands.

## Operation
Acceptance:
- accept = id_valid_i & ~ex_stall_i & ~st_flush_i & ~bu_flush_o & (state==IDLE).
- A non-accepted cycle with ~ex_stall_i clears bu_valid_o, bu_flush_o and bu_bp_update_o.
- ex_stall_i holds every output and all state.

Resolution:
- len = id_rvc_i ? 2 : 4.
- Conditional branches: taken uses signed compares for BLT/BGE and unsigned for BLTU/BGEU. target = taken ? pc+imm : pc+len. flush = taken ^ predict[1].
- JAL: target = pc+imm, flush = ~predict[1].
- Misaligned target: bit 0 set when HAS_RVC is non-zero, otherwise any of bits [1:0] set. This applies only to taken or jump targets. On misalignment: bu_misaligned_o=1, flush=0, no RSB or history update.

RSB (link = x1 or x5):
- JAL with link rd: push pc+len.
- JALR, rd link and rs1 not link: push.
- JALR, rs1 link and rd not link: pop.
- JALR, both link and rs1≠rd: pop then push.
- JALR, both link and rs1==rd: push only.
- Push writes entry at wr_ptr and increments wr_ptr modulo RSB_DEPTH. count saturates at RSB_DEPTH; on overflow the oldest entry is overwritten.
- Pop reads entry wr_ptr-1 and decrements the pointer; count decrements.
- Pop with count==0: entry treated as mismatch, pointer unchanged.
- JALR flush = ~(popped & count≠0 & popped value[XLEN-1:1]==target[XLEN-1:1]). Otherwise JALR flush = 1. With RSB_DEPTH==0, JALR always flushes.

History:
- On each accepted conditional branch, hist <= {hist[BP_GLOBAL_BITS-1:0], taken}.
- bu_bp_history_o = hist[BP_GLOBAL_BITS:1].

FENCE.I state machine:
- States IDLE, WAIT, DONE.
- IDLE, accepted FENCEI: pulse cm_ic_invalidate_o and cm_dc_clean_o for 1 cycle, capture pc+len, go to WAIT. bu_stall_o=1 in WAIT and DONE.
- WAIT, cm_ack_i: go to DONE. st_flush_i does not abort WAIT.
- DONE: present bu_valid_o=1, bu_flush_o=1, bu_nxt_pc_o=pc+len; return to IDLE.

## Timing
- Reset values: bu_flush_o=1, bu_nxt_pc_o=PC_INIT, all other outputs 0, state IDLE, RSB count/pointer 0, hist 0.
- Outputs are valid 1 cycle after accept. FENCE.I flush appears 1 cycle after cm_ack_i.
- The instruction in ID during the cycle bu_flush_o=1 is wrong-path and is dropped.
- st_flush_i in the same cycle as accept: the instruction is dropped and has no RSB or history effect.
- Reset asserted mid-FENCE.I returns to IDLE with reset values; no cm command is reissued.

## Test plan
- BEQ, opA=opB=5, pc=0x100, imm=0x20, predict=00 -> next cycle: valid=1, btaken=1, flush=1, nxt_pc=0x120, bp_update=1, history LSB shifted in =1.
- BLT, opA=0xFFFFFFFF, opB=1, predict=10 -> taken, flush=0. Same operands with BLTU -> not taken, flush=1, nxt_pc=pc+4.
- JAL rd=x1 at pc 0x200, then JALR rd=x0 rs1=x1 with target 0x204 -> second JALR flush=0. Repeat with target 0x208 -> flush=1.
- RSB_DEPTH=4: five calls then five returns -> first four returns match (LIFO), fifth flushes (count 0).
- HAS_RVC=0, JALR target 0x102 -> misaligned=1, flush=0, RSB unchanged.
- FENCEI at pc 0x300: cm pulses for 1 cycle, bu_stall_o high; cm_ack_i after 7 cycles -> next cycle flush=1, nxt_pc=0x304. st_flush_i during WAIT is ignored.
